// File: rtl/vx_ti_fetch_unit_pkg.sv
// Shared definitions for the triangle-intersection fetch unit: word/tag widths,
// default node size and the fetch FSM state encoding.
package vx_ti_fetch_unit_pkg;

    localparam int unsigned TI_WORD_BITS = 32;
    localparam int unsigned TI_MAX_WORDS = 12;
    localparam int unsigned TI_TAG_BITS  = 4;

    typedef logic [TI_TAG_BITS-1:0] ti_tag_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } ti_state_e;

    // Word count of a request, saturated to the buffer depth.
    function automatic ti_tag_t ti_clamp_count(input logic [3:0] words, input int unsigned max_words);
        if (32'(words) > max_words) begin
            return ti_tag_t'(max_words);
        end
        return words;
    endfunction

endpackage

// File: rtl/vx_ti_fetch_unit_if.sv
// Request/response and memory-side handshake bundle of the fetch unit.
// The master modport is the fetch unit itself; slave is the controller plus memory.
interface vx_ti_fetch_unit_if
    import vx_ti_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 32,
    parameter int unsigned MAX_WORDS = TI_MAX_WORDS
) ();

    logic                              req_valid;
    logic [ADDR_BITS-1:0]              req_addr;
    logic [5:0]                        req_size;
    logic                              req_ready;

    logic                              rsp_valid;
    logic [MAX_WORDS*TI_WORD_BITS-1:0] rsp_data;
    logic                              rsp_ready;

    logic                              mem_req_valid;
    logic [ADDR_BITS-3:0]              mem_req_addr;
    ti_tag_t                           mem_req_tag;
    logic                              mem_req_ready;

    logic                              mem_rsp_valid;
    logic [TI_WORD_BITS-1:0]           mem_rsp_data;
    ti_tag_t                           mem_rsp_tag;
    logic                              mem_rsp_ready;

    modport master (
        input  req_valid, req_addr, req_size, rsp_ready,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        output req_ready, rsp_valid, rsp_data,
        output mem_req_valid, mem_req_addr, mem_req_tag, mem_rsp_ready
    );

    modport slave (
        output req_valid, req_addr, req_size, rsp_ready,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        input  req_ready, rsp_valid, rsp_data,
        input  mem_req_valid, mem_req_addr, mem_req_tag, mem_rsp_ready
    );

endinterface

// File: rtl/vx_ti_fetch_unit_buf.sv
// Assembly buffer for fetched words plus received mask; writes are filtered so
// only first arrivals of in-range tags land, and full_next looks ahead one write.
module vx_ti_fetch_unit_buf
    import vx_ti_fetch_unit_pkg::*;
#(
    parameter int unsigned MAX_WORDS = TI_MAX_WORDS
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              clear,
    input  logic                              wr_req,
    input  ti_tag_t                           wr_idx,
    input  logic [TI_WORD_BITS-1:0]           wr_data,
    input  ti_tag_t                           n,
    output logic [MAX_WORDS*TI_WORD_BITS-1:0] data,
    output logic                              full_next
);

    logic [MAX_WORDS-1:0][TI_WORD_BITS-1:0] words;
    logic [MAX_WORDS-1:0]                   mask;
    logic [MAX_WORDS-1:0]                   wr_sel;
    logic [MAX_WORDS-1:0]                   need;

    always_comb begin
        wr_sel = '0;
        need   = '0;
        for (int unsigned i = 0; i < MAX_WORDS; i++) begin
            need[i]   = (i < 32'(n));
            wr_sel[i] = wr_req && (32'(wr_idx) == i) && need[i] && !mask[i];
        end
    end

    // Counts the write landing this cycle so completion is seen one edge earlier.
    assign full_next = ((mask | wr_sel) & need) == need;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            words <= '0;
            mask  <= '0;
        end else if (clear) begin
            words <= '0;
            mask  <= '0;
        end else begin
            for (int unsigned i = 0; i < MAX_WORDS; i++) begin
                if (wr_sel[i]) begin
                    words[i] <= wr_data;
                    mask[i]  <= 1'b1;
                end
            end
        end
    end

    assign data = words;

endmodule

// File: rtl/vx_ti_fetch_unit.sv
// Fetches up to MAX_WORDS consecutive 32-bit words for the T&I controller,
// issuing one tagged memory read per cycle and assembling out-of-order returns.
module vx_ti_fetch_unit
    import vx_ti_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 32,
    parameter int unsigned MAX_WORDS = TI_MAX_WORDS
) (
    input  logic               clk,
    input  logic               reset_n,
    vx_ti_fetch_unit_if.master bus
);

    localparam int unsigned WADDR_BITS = ADDR_BITS - 2;

    ti_state_e             state, state_next;
    logic                  active;
    logic [WADDR_BITS-1:0] base, base_next;
    ti_tag_t               n, n_next;
    ti_tag_t               idx, idx_next;
    logic                  buf_clear;
    logic                  wr_req;
    logic                  full_next;
    logic                  unused_low_bits;

    assign unused_low_bits = ^{bus.req_addr[1:0], bus.req_size[1:0]};

    // active keeps the ready outputs low while reset is held and for the
    // release cycle, even though the state register already reads IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            active <= 1'b0;
            base   <= '0;
            n      <= '0;
            idx    <= '0;
        end else begin
            state  <= state_next;
            active <= 1'b1;
            base   <= base_next;
            n      <= n_next;
            idx    <= idx_next;
        end
    end

    always_comb begin
        state_next        = state;
        base_next         = base;
        n_next            = n;
        idx_next          = idx;
        buf_clear         = 1'b0;
        bus.req_ready     = 1'b0;
        bus.rsp_valid     = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_addr  = base + WADDR_BITS'(idx);
        bus.mem_req_tag   = idx;
        bus.mem_rsp_ready = active;
        wr_req            = active && bus.mem_rsp_valid &&
                            (state == ST_ISSUE || state == ST_WAIT);

        case (state)
            ST_IDLE: begin
                bus.req_ready = active;
                if (active && bus.req_valid) begin
                    base_next  = bus.req_addr[ADDR_BITS-1:2];
                    n_next     = ti_clamp_count(bus.req_size[5:2], MAX_WORDS);
                    idx_next   = '0;
                    buf_clear  = 1'b1;
                    state_next = (n_next == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) begin
                    idx_next = idx + ti_tag_t'(1);
                end
                // A stray in-range response may complete the node before issue ends.
                if (full_next) begin
                    state_next = ST_DONE;
                end else if (bus.mem_req_ready && (idx + ti_tag_t'(1)) == n) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (full_next) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    vx_ti_fetch_unit_buf #(
        .MAX_WORDS (MAX_WORDS)
    ) u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (buf_clear),
        .wr_req    (wr_req),
        .wr_idx    (bus.mem_rsp_tag),
        .wr_data   (bus.mem_rsp_data),
        .n         (n),
        .data      (bus.rsp_data),
        .full_next (full_next)
    );

    a_mem_req_stable: assert property (@(posedge clk) disable iff (!reset_n)
        bus.mem_req_valid && !bus.mem_req_ready |=>
            bus.mem_req_valid && $stable(bus.mem_req_addr) && $stable(bus.mem_req_tag));

    a_rsp_stable: assert property (@(posedge clk) disable iff (!reset_n)
        bus.rsp_valid && !bus.rsp_ready |=> bus.rsp_valid && $stable(bus.rsp_data));

endmodule
